// File: rtl/mat_job_arbiter.sv
// mat_job_arbiter: two-requester job arbiter in front of a single matrix
// accumulation engine. Grants one job at a time, issues it to the engine,
// supervises it with a RUN timeout and reports completion or timeout back to
// the owning requester. All outputs are decoded from registered state only.
module mat_job_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic              eng_ready,
  input  logic              eng_done,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_base,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic [7:0]        job_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    RUN      = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  // Timer value on the last RUN cycle a job is allowed before it is aborted.
  localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT_CYC - 1);

  state_t              state_reg, state_next;
  logic                gnt_idx_reg, gnt_idx_next;
  logic                last_gnt_reg, last_gnt_next;
  logic                status_ok_reg, status_ok_next;
  logic [9:0]          timer_reg, timer_next;
  logic [7:0]          job_count_reg, job_count_next;
  logic [ADDR_W-1:0]   eng_base_reg, eng_base_next;

  logic                req_granted;
  logic                winner;
  logic [1:0]          gnt_vec;
  logic [1:0]          done_vec;
  logic [1:0]          err_vec;

  // Request line of the requester currently holding the grant.
  assign req_granted = gnt_idx_reg ? req1 : req0;

  // Winner selection in IDLE: a lone requester wins, a tie goes to the
  // requester that was not served last.
  assign winner = (req0 && req1) ? ~last_gnt_reg : req1;

  // State register; reset abandons any job in flight without reporting it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      gnt_idx_reg   <= 1'b0;
      last_gnt_reg  <= 1'b1;
      status_ok_reg <= 1'b0;
      timer_reg     <= 10'd0;
      job_count_reg <= 8'd0;
      eng_base_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_idx_reg   <= gnt_idx_next;
      last_gnt_reg  <= last_gnt_next;
      status_ok_reg <= status_ok_next;
      timer_reg     <= timer_next;
      job_count_reg <= job_count_next;
      eng_base_reg  <= eng_base_next;
    end
  end

  // Next-state logic: arbitration, issue handshake, RUN supervision and
  // completion bookkeeping.
  always_comb begin
    state_next     = state_reg;
    gnt_idx_next   = gnt_idx_reg;
    last_gnt_next  = last_gnt_reg;
    status_ok_next = status_ok_reg;
    timer_next     = timer_reg;
    job_count_next = job_count_reg;
    eng_base_next  = eng_base_reg;

    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          gnt_idx_next  = winner;
          eng_base_next = winner ? base1 : base0;
          state_next    = ISSUE;
        end
      end

      ISSUE: begin
        // Acceptance wins over a withdrawal seen on the same edge; a
        // withdrawal leaves last_gnt alone so fairness is not disturbed.
        if (eng_ready) begin
          timer_next = 10'd0;
          state_next = RUN;
        end else if (!req_granted) begin
          state_next = IDLE;
        end
      end

      RUN: begin
        // Requests are deliberately ignored here: once the engine owns the
        // job it runs to completion or timeout.
        if (eng_done) begin
          status_ok_next = 1'b1;
          job_count_next = (job_count_reg == 8'hFF) ? 8'hFF : job_count_reg + 8'd1;
          state_next     = COMPLETE;
        end else if (timer_reg == TIMER_LAST) begin
          status_ok_next = 1'b0;
          state_next     = COMPLETE;
        end else begin
          timer_next = timer_reg + 10'd1;
        end
      end

      COMPLETE: begin
        last_gnt_next = gnt_idx_reg;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-requester grant and status pulses decoded from registered state.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign gnt_vec[gi]  = (state_reg != IDLE) && (gnt_idx_reg == 1'(gi));
      assign done_vec[gi] = (state_reg == COMPLETE) && status_ok_reg && (gnt_idx_reg == 1'(gi));
      assign err_vec[gi]  = (state_reg == COMPLETE) && !status_ok_reg && (gnt_idx_reg == 1'(gi));
    end
  endgenerate

  assign gnt0      = gnt_vec[0];
  assign gnt1      = gnt_vec[1];
  assign done0     = done_vec[0];
  assign done1     = done_vec[1];
  assign err0      = err_vec[0];
  assign err1      = err_vec[1];
  assign eng_start = (state_reg == ISSUE);
  assign busy      = (state_reg != IDLE);
  assign eng_base  = eng_base_reg;
  assign job_count = job_count_reg;

endmodule
